// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode constants and FSM state type for the bit-serial
//             (slice-serial) ALU alu_seq.
//  Contents : OP_* opcode encodings, state_t FSM state enum.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ZERO = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// ============================================================================
//  Module   : alu_slice
//  Purpose  : Combinational SLICE-bit datapath: AND, OR and add with
//             optional inversion of b on the adder path.
//  Ports    : a_i, b_i      slice operands
//             inv_b_i       invert b into the adder only (logic ops see raw b)
//             cin_i         carry into bit 0 of the slice
//             and_o, or_o   bitwise results
//             sum_o, cout_o adder sum and carry out of the slice MSB
//             msb_cin_o     carry into the slice MSB (for signed overflow)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             inv_b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] and_o,
    output logic [SLICE-1:0] or_o,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o,
    output logic             msb_cin_o
);

    logic [SLICE-1:0] w_b_add;
    logic [SLICE:0]   w_full;

    assign w_b_add = inv_b_i ? ~b_i : b_i;
    assign w_full  = {1'b0, a_i} + {1'b0, w_b_add} + {{SLICE{1'b0}}, cin_i};

    assign and_o  = a_i & b_i;
    assign or_o   = a_i | b_i;
    assign sum_o  = w_full[SLICE-1:0];
    assign cout_o = w_full[SLICE];

    // sum[msb] = a ^ b ^ cin_msb, so the carry into the MSB falls out of the sum.
    assign msb_cin_o = w_full[SLICE-1] ^ a_i[SLICE-1] ^ w_b_add[SLICE-1];

endmodule : alu_slice
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Multi-cycle ALU processing WIDTH-bit operands SLICE bits per
//             cycle, LSB slice first, carry chained through a register.
//             Result and flags appear WIDTH/SLICE cycles after acceptance and
//             are held until the valid/ready handshake completes.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid / in_ready   operation handshake (ready only in IDLE)
//             a, b, alu_op, control operands, opcode, ADD carry-in
//             out_valid / out_ready result handshake
//             result, carry_out, overflow, zero  registered outputs
//  Macro    : ALU_SLT_EN - enables signed set-less-than on opcode 111;
//             when undefined, opcode 111 behaves as opcode 011 (zero).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    input  logic             control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("alu_seq: SLICE must be >= 1 and divide WIDTH");
        end
    endgenerate

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
    logic [2:0]       op_q;
    logic             ctl_q, carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             out_valid_q, cout_q, ovf_q, zero_q;

    logic [SLICE-1:0] w_a_sl, w_b_sl, w_and, w_or, w_sum, w_sl_res;
    logic             w_cin, w_cout, w_msb_cin, w_ovf_raw;
    logic             w_is_add, w_is_slt;
    logic [WIDTH-1:0] w_acc_next, w_final;

    assign w_a_sl   = a_q[idx_q*SLICE +: SLICE];
    assign w_b_sl   = b_q[idx_q*SLICE +: SLICE];
    assign w_is_add = (op_q == OP_ADD) || (op_q == OP_SUB);
`ifdef ALU_SLT_EN
    assign w_is_slt = (op_q == OP_SLT);
`else
    assign w_is_slt = 1'b0;
`endif

    // First slice takes the operation's carry-in; later slices chain the register.
    assign w_cin = (idx_q == '0) ? ((op_q == OP_ADD) ? ctl_q : 1'b1) : carry_q;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a_i       (w_a_sl),
        .b_i       (w_b_sl),
        .inv_b_i   (op_q[2]),
        .cin_i     (w_cin),
        .and_o     (w_and),
        .or_o      (w_or),
        .sum_o     (w_sum),
        .cout_o    (w_cout),
        .msb_cin_o (w_msb_cin)
    );

    // Only meaningful on the last slice, where it is the full-width overflow.
    assign w_ovf_raw = w_msb_cin ^ w_cout;

    always_comb begin
        w_sl_res = '0;
        if (!op_q[1]) begin
            w_sl_res = op_q[0] ? w_or : w_and;
        end else if (w_is_add || w_is_slt) begin
            w_sl_res = w_sum;
        end
    end

    always_comb begin
        w_acc_next = acc_q;
        w_acc_next[idx_q*SLICE +: SLICE] = w_sl_res;
    end

    // SLT: sign of (a-b) corrected by overflow gives the signed comparison.
    always_comb begin
        w_final = w_acc_next;
        if (w_is_slt) begin
            w_final    = '0;
            w_final[0] = w_acc_next[WIDTH-1] ^ w_ovf_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            ctl_q       <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= alu_op;
                        ctl_q   <= control;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                        acc_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_q <= w_cout;
                    acc_q   <= w_acc_next;
                    if (idx_q == LAST_IDX) begin
                        result_q    <= w_final;
                        cout_q      <= w_is_add & w_cout;
                        ovf_q       <= w_is_add & w_ovf_raw;
                        zero_q      <= (w_final == '0);
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (WIDTH=32, SLICE=8): directed
//             corner cases plus random operations against an arithmetic
//             reference model. Honours ALU_SLT_EN for opcode 111.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int LAT   = WIDTH / SLICE;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic [2:0]        alu_op = '0;
    logic              control = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  result;
    logic              carry_out, overflow, zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    typedef struct packed {
        logic        z;
        logic        ov;
        logic        co;
        logic [31:0] res;
    } exp_t;

    // Reference: whole-word arithmetic straight from the opcode definitions.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic [2:0] op, input logic c);
        exp_t        e;
        logic [32:0] s;
        e = '0;
        s = '0;
        case (op)
            3'b000, 3'b100: e.res = av & bv;
            3'b001, 3'b101: e.res = av | bv;
            3'b010: begin
                s     = {1'b0, av} + {1'b0, bv} + {32'd0, c};
                e.res = s[31:0];
                e.co  = s[32];
                e.ov  = (av[31] == bv[31]) && (e.res[31] != av[31]);
            end
            3'b110: begin
                s     = {1'b0, av} + {1'b0, ~bv} + 33'd1;
                e.res = s[31:0];
                e.co  = s[32];
                e.ov  = (av[31] != bv[31]) && (e.res[31] != av[31]);
            end
            3'b111: begin
`ifdef ALU_SLT_EN
                e.res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
`else
                e.res = 32'd0;
`endif
            end
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation starting at a negedge; checks latency, result, flags,
    // hold behaviour for 'stall' cycles, then completes the handshake.
    task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [2:0] op, input logic c, input int stall, input bit garble);
        exp_t e;
        int   waited;
        e = model(av, bv, op, c);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
        a = av; b = bv; alu_op = op; control = c; in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check({tag, "/out_valid_early"}, 64'(out_valid), 64'd0);
            if (k == 0) check({tag, "/in_ready_busy"}, 64'(in_ready), 64'd0);
            if (garble) begin
                a = $urandom; b = $urandom; alu_op = 3'($urandom);
                control = 1'($urandom); in_valid = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, "/out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "/result"},    64'(result),    64'(e.res));
        check({tag, "/carry_out"}, 64'(carry_out), 64'(e.co));
        check({tag, "/overflow"},  64'(overflow),  64'(e.ov));
        check({tag, "/zero"},      64'(zero),      64'(e.z));
        for (int s = 0; s < stall; s++) begin
            if (garble) begin
                a = $urandom; b = $urandom; in_valid = ~in_valid;
            end
            @(negedge clk);
            check({tag, "/hold_result"},   64'(result),    64'(e.res));
            check({tag, "/hold_out_valid"}, 64'(out_valid), 64'd1);
            check({tag, "/hold_in_ready"},  64'(in_ready),  64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "/out_valid_clear"}, 64'(out_valid), 64'd0);
        check({tag, "/in_ready_after"},  64'(in_ready),  64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset/in_ready",  64'(in_ready),  64'd1);
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/result",    64'(result),    64'd0);
        check("reset/carry_out", 64'(carry_out), 64'd0);
        check("reset/overflow",  64'(overflow),  64'd0);
        check("reset/zero",      64'(zero),      64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases
        do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b0, 0, 1'b0);
        do_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 3'b110, 1'b0, 0, 1'b0);
        do_op("slt_neg",  32'hFFFF_FFFE, 32'h0000_0003, 3'b111, 1'b0, 0, 1'b0);
        do_op("and_hold", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b0, 5, 1'b1);
        do_op("op011",    $urandom,      $urandom,      3'b011, 1'b1, 1, 1'b0);
        do_op("add_cin",  32'h7FFF_FFFF, 32'h0000_0000, 3'b010, 1'b1, 0, 1'b0);
        do_op("or_hi",    32'h1234_0000, 32'h0000_5678, 3'b101, 1'b1, 0, 1'b0);

        // Reset in the middle of RUN after two slices
        a = 32'h1111_1111; b = 32'h2222_2222; alu_op = 3'b010; control = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst/in_ready",  64'(in_ready),  64'd1);
        check("midrst/out_valid", 64'(out_valid), 64'd0);
        check("midrst/result",    64'(result),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            check("midrst/no_result", 64'(out_valid), 64'd0);
        end
        check("midrst/idle", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        // Random operations with random stalls and ignored in_valid noise
        for (int i = 0; i < 30; i++) begin
            do_op("rand", $urandom, $urandom, 3'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SLICE, default 8, bits processed per cycle; SLICE >= 1 and WIDTH % SLICE == 0 SHALL hold, else elaboration error.
REQ-003 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands/opcode valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 alu_op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (macro), 100 AND, 101 OR, 011 zero.
REQ-009 control  input  1  carry-in for ADD.
REQ-010 out_valid  output  1  result registers valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 carry_out, overflow, zero  output  1 each  registered flags.

Function
REQ-014 States IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: in_valid=1 SHALL capture a, b, alu_op, control, clear slice index and carry register, go RUN.
REQ-016 RUN: each cycle SHALL process slice k (bits k*SLICE .. k*SLICE+SLICE-1), LSB slice first, carry chained via register; after slice WIDTH/SLICE-1 SHALL go DONE.
REQ-017 Latency: out_valid SHALL rise exactly WIDTH/SLICE cycles after the accepting edge.
REQ-018 Adder input: b inverted when alu_op[2]=1; carry-in = control for 010, 1 for 110 and 111.
REQ-019 Logic ops (00x, 10x) SHALL use uninverted b; carry_out and overflow 0.
REQ-020 ADD/SUB: carry_out = final adder carry; overflow = carry into MSB xor carry out of MSB.
REQ-021 Opcode 011: result 0, carry_out 0, overflow 0.
REQ-022 zero SHALL be 1 iff final result == 0, all opcodes.
REQ-023 DONE: outputs SHALL hold stable while out_ready=0; out_valid & out_ready SHALL return to IDLE; no accept in that same cycle.
REQ-024 in_valid during RUN/DONE SHALL be ignored; captured operands SHALL not change mid-operation.
REQ-025 WIDTH == SLICE SHALL give one RUN cycle (latency 1).

Reset
REQ-026 rst_n=0 SHALL force IDLE immediately, any state, discarding in-flight work.
REQ-027 Reset values: out_valid 0, result 0, carry_out 0, overflow 0, zero 0, slice index 0, carry 0; in_ready 1 once in IDLE.

Configuration
REQ-028 Macro ALU_SLT_EN defined: opcode 111 SHALL yield result = {WIDTH-1 zeros, sign(a-b) xor overflow}, carry_out and overflow 0.
REQ-029 ALU_SLT_EN undefined: opcode 111 SHALL behave as 011 (result 0, flags 0 except zero=1).

Structure
REQ-030 Package alu_pkg SHALL hold opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT) and the state enum typedef.
REQ-031 Sub-module alu_slice SHALL be the combinational SLICE-bit datapath (and/or/add, carry in/out, MSB carry-in output), instantiated once.

Verification (WIDTH=32, SLICE=8)
REQ-032 Reset mid-RUN after 2 slices -> in_ready 1, out_valid 0 next cycle, no result emitted.
REQ-033 ADD a=0xFFFFFFFF, b=1, control=0 -> result 0, carry_out 1, overflow 0, zero 1, out_valid 4 cycles after accept.
REQ-034 SUB a=0x80000000, b=1 -> result 0x7FFFFFFF, overflow 1, carry_out 1, zero 0.
REQ-035 SLT a=0xFFFFFFFE (-2), b=3: with ALU_SLT_EN result 1; without, result 0, zero 1.
REQ-036 AND a=0xF0F0F0F0, b=0xFF00FF00, out_ready held 0 for 5 cycles -> result 0xF000F000 stable, in_valid pulses ignored, in_ready 0 until handshake.
REQ-037 Opcode 011 with any operands -> result 0, carry_out 0, zero 1.
